// File: rtl/display_pkg.sv
// ---------------------------------------------------------------------------
// display_pkg
// Shared definitions for the multiplexed 7-segment display scanner.
//   - state_t    : scanner state machine states (OFF, ON, GAP)
//   - SEG_0..7   : active-low segment patterns, bit order [0:6] = a..g
//   - SEG_BLANK  : all segments off
//   - max_int    : helper used to size the shared cycle counter
// ---------------------------------------------------------------------------
package display_pkg;

  typedef enum logic [1:0] {
    OFF = 2'd0,
    ON  = 2'd1,
    GAP = 2'd2
  } state_t;

  // Literal bits read left to right as a, b, c, d, e, f, g.
  localparam logic [0:6] SEG_0     = 7'b0000001;
  localparam logic [0:6] SEG_1     = 7'b1001111;
  localparam logic [0:6] SEG_2     = 7'b0010010;
  localparam logic [0:6] SEG_3     = 7'b0000110;
  localparam logic [0:6] SEG_4     = 7'b1001100;
  localparam logic [0:6] SEG_5     = 7'b0100100;
  localparam logic [0:6] SEG_6     = 7'b0100000;
  localparam logic [0:6] SEG_7     = 7'b0001111;
  localparam logic [0:6] SEG_BLANK = 7'b1111111;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// ---------------------------------------------------------------------------
// seg7_decode
// Purely combinational 3-bit value to active-low 7-segment pattern decoder.
// Ports:
//   value   in  3   digit value 0..7
//   pattern out 7   active-low segments, [0:6] = a..g
// ---------------------------------------------------------------------------
module seg7_decode
  import display_pkg::*;
(
  input  logic [2:0] value,
  output logic [0:6] pattern
);

  always_comb begin
    pattern = SEG_BLANK;
    case (value)
      3'd0:    pattern = SEG_0;
      3'd1:    pattern = SEG_1;
      3'd2:    pattern = SEG_2;
      3'd3:    pattern = SEG_3;
      3'd4:    pattern = SEG_4;
      3'd5:    pattern = SEG_5;
      3'd6:    pattern = SEG_6;
      3'd7:    pattern = SEG_7;
      default: pattern = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/display_scanner.sv
// ---------------------------------------------------------------------------
// display_scanner
// Time-multiplexed controller for NUM_DIGITS common-anode 7-segment digits
// sharing one decoder. Each digit is lit for PRESCALE cycles, followed by
// GAP_CYCLES cycles with every anode off. New digit sets arrive through a
// load/ready handshake and are committed only at frame boundaries so a
// frame never mixes old and new values.
//
// Parameters:
//   NUM_DIGITS  number of digits scanned (>= 2)
//   PRESCALE    cycles each digit is lit (>= 2)
//   GAP_CYCLES  blanking cycles between digits (>= 1)
// Ports:
//   clock      in   1              sole clock, rising edge
//   reset      in   1              asynchronous, active-high
//   habilita   in   1              display enable
//   load       in   1              request to accept valores
//   valores    in   3*NUM_DIGITS   digit i = bits [3i+2:3i]
//   ready      out  1              a load will be accepted
//   segmentos  out  7              active-low segments, [0:6] = a..g
//   anodos     out  NUM_DIGITS     active-low digit enables
// Build option:
//   DISPLAY_ZERO_SUPPRESS_EN  blank leading zero digits (digit 0 always shown)
// ---------------------------------------------------------------------------
module display_scanner
  import display_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 50000,
  parameter int GAP_CYCLES = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    habilita,
  input  logic                    load,
  input  logic [3*NUM_DIGITS-1:0] valores,
  output logic                    ready,
  output logic [0:6]              segmentos,
  output logic [NUM_DIGITS-1:0]   anodos
);

  localparam int CNT_W = $clog2(max_int(PRESCALE, GAP_CYCLES));
  localparam int IDX_W = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t                  state_reg,         state_next;
  logic [IDX_W-1:0]        index_reg,         index_next;
  logic [CNT_W-1:0]        count_reg,         count_next;
  logic [3*NUM_DIGITS-1:0] active_reg,        active_next;
  logic [3*NUM_DIGITS-1:0] pending_reg,       pending_next;
  logic                    pending_valid_reg, pending_valid_next;
  logic [0:6]              seg_reg,           seg_next;
  logic [NUM_DIGITS-1:0]   anod_reg,          anod_next;

  // A single pending slot: ready simply mirrors its emptiness, which also
  // guarantees a commit and a capture can never coincide.
  logic capture;
  assign capture = load && !pending_valid_reg;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next         = state_reg;
    index_next         = index_reg;
    count_next         = count_reg;
    active_next        = active_reg;
    pending_next       = pending_reg;
    pending_valid_next = pending_valid_reg;

    case (state_reg)
      OFF: begin
        index_next = '0;
        count_next = '0;
        // A set left pending by an enable drop commits on the first OFF
        // cycle; otherwise a load goes straight to the displayed values.
        if (pending_valid_reg) begin
          active_next        = pending_reg;
          pending_valid_next = 1'b0;
        end else if (load) begin
          active_next = valores;
        end
        if (habilita) begin
          state_next = ON;
        end
      end

      ON: begin
        if (capture) begin
          pending_next       = valores;
          pending_valid_next = 1'b1;
        end
        if (!habilita) begin
          state_next = OFF;
          index_next = '0;
          count_next = '0;
        end else if (count_reg == ON_LAST) begin
          state_next = GAP;
          count_next = '0;
        end else begin
          count_next = count_reg + 1'b1;
        end
      end

      GAP: begin
        if (capture) begin
          pending_next       = valores;
          pending_valid_next = 1'b1;
        end
        if (!habilita) begin
          state_next = OFF;
          index_next = '0;
          count_next = '0;
        end else if (count_reg == GAP_LAST) begin
          state_next = ON;
          count_next = '0;
          if (index_reg == IDX_LAST) begin
            // Frame end: digit 0 of the next frame shows the new set.
            index_next = '0;
            if (pending_valid_reg) begin
              active_next        = pending_reg;
              pending_valid_next = 1'b0;
            end
          end else begin
            index_next = index_reg + 1'b1;
          end
        end else begin
          count_next = count_reg + 1'b1;
        end
      end

      default: begin
        state_next = OFF;
        index_next = '0;
        count_next = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Digit selection and decode
  // -------------------------------------------------------------------------
  logic [2:0] digit_vals [NUM_DIGITS];

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign digit_vals[gi] = active_reg[3*gi +: 3];
    end
  endgenerate

  logic [0:6] decoded;

  seg7_decode u_decode (
    .value   (digit_vals[index_reg]),
    .pattern (decoded)
  );

  logic suppress;

`ifdef DISPLAY_ZERO_SUPPRESS_EN
  // zero_from[i] is set when digit i and every digit above it are zero.
  logic [NUM_DIGITS:0] zero_from;
  assign zero_from[NUM_DIGITS] = 1'b1;

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_zero
      assign zero_from[gi] = (digit_vals[gi] == 3'd0) && zero_from[gi+1];
    end
  endgenerate

  assign suppress = (index_reg != '0) && zero_from[index_reg];
`else
  assign suppress = 1'b0;
`endif

  // Outputs are registered from the current state, so they trail the state
  // machine by one cycle.
  always_comb begin
    seg_next  = SEG_BLANK;
    anod_next = '1;
    if (state_reg == ON && !suppress) begin
      seg_next  = decoded;
      anod_next = ~(NUM_DIGITS'(1) << index_reg);
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg         <= OFF;
      index_reg         <= '0;
      count_reg         <= '0;
      active_reg        <= '0;
      pending_reg       <= '0;
      pending_valid_reg <= 1'b0;
      seg_reg           <= SEG_BLANK;
      anod_reg          <= '1;
    end else begin
      state_reg         <= state_next;
      index_reg         <= index_next;
      count_reg         <= count_next;
      active_reg        <= active_next;
      pending_reg       <= pending_next;
      pending_valid_reg <= pending_valid_next;
      seg_reg           <= seg_next;
      anod_reg          <= anod_next;
    end
  end

  assign ready     = ~pending_valid_reg;
  assign segmentos = seg_reg;
  assign anodos    = anod_reg;

endmodule

// File: tb/tb_display_scanner.sv
// ---------------------------------------------------------------------------
// tb_display_scanner
// Self-checking bench for display_scanner with NUM_DIGITS=4, PRESCALE=4,
// GAP_CYCLES=2. A cycle-count reference model (frame position = cycles since
// scanning started, modulo the frame period) predicts every output.
// ---------------------------------------------------------------------------
module tb_display_scanner;

  localparam int N     = 4;
  localparam int P     = 4;
  localparam int G     = 2;
  localparam int DPER  = P + G;
  localparam int FRAME = N * DPER;

  logic           clk;
  logic           reset;
  logic           habilita;
  logic           load;
  logic [3*N-1:0] valores;
  logic           ready;
  logic [0:6]     segmentos;
  logic [N-1:0]   anodos;

  int n_vec;
  int n_err;

  display_scanner #(
    .NUM_DIGITS (N),
    .PRESCALE   (P),
    .GAP_CYCLES (G)
  ) dut (
    .clock     (clk),
    .reset     (reset),
    .habilita  (habilita),
    .load      (load),
    .valores   (valores),
    .ready     (ready),
    .segmentos (segmentos),
    .anodos    (anodos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // -------------------------------------------------------------------------
  // Reference model
  // -------------------------------------------------------------------------
  bit             m_on;
  int             m_t;
  logic [3*N-1:0] m_active;
  logic [3*N-1:0] m_pending;
  bit             m_pv;
  logic [0:6]     m_seg;
  logic [N-1:0]   m_anod;
  logic           m_ready;

  function automatic logic [0:6] seg_of(input logic [2:0] v);
    logic [0:6] tbl [8];
    tbl[0] = 7'b0000001; tbl[1] = 7'b1001111; tbl[2] = 7'b0010010;
    tbl[3] = 7'b0000110; tbl[4] = 7'b1001100; tbl[5] = 7'b0100100;
    tbl[6] = 7'b0100000; tbl[7] = 7'b0001111;
    return tbl[v];
  endfunction

  task automatic model_reset();
    m_on = 0; m_t = 0; m_active = '0; m_pending = '0; m_pv = 0;
    m_seg = 7'b1111111; m_anod = '1; m_ready = 1'b1;
  endtask

  // Advance one clock: outputs after the edge follow the pre-edge position.
  task automatic tick();
    int ph;
    int d;
    bit sup;
    @(posedge clk);
    ph  = m_t % FRAME;
    d   = ph / DPER;
    sup = 0;
    if (m_on && (ph % DPER) < P) begin
`ifdef DISPLAY_ZERO_SUPPRESS_EN
      sup = (d > 0) && ((m_active >> (3*d)) == '0);
`endif
      if (sup) begin
        m_seg = 7'b1111111; m_anod = '1;
      end else begin
        m_seg  = seg_of(m_active[3*d +: 3]);
        m_anod = ~(N'(1) << d);
      end
    end else begin
      m_seg = 7'b1111111; m_anod = '1;
    end
    if (!m_on) begin
      if (m_pv) begin
        m_active = m_pending; m_pv = 0;
      end else if (load) begin
        m_active = valores;
      end
      if (habilita) begin
        m_on = 1; m_t = 0;
      end
    end else begin
      if (load && !m_pv) begin
        m_pending = valores; m_pv = 1;
      end else if (ph == FRAME-1 && m_pv && habilita) begin
        m_active = m_pending; m_pv = 0;
      end
      if (!habilita) begin
        m_on = 0; m_t = 0;
      end else begin
        m_t = (m_t + 1) % FRAME;
      end
    end
    m_ready = !m_pv;
    #1;
  endtask

  // -------------------------------------------------------------------------
  // Scenarios
  // -------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b1; habilita = 1'b0; load = 1'b0; valores = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (segmentos !== 7'b1111111) begin
      n_err++; $display("FAIL reset_seg: got %b want 1111111", segmentos);
    end
    n_vec++;
    if (anodos !== 4'b1111) begin
      n_err++; $display("FAIL reset_anod: got %b want 1111", anodos);
    end
    n_vec++;
    if (ready !== 1'b1) begin
      n_err++; $display("FAIL reset_ready: got %b want 1", ready);
    end
    $display("reset: seg=%b an=%b rdy=%b", segmentos, anodos, ready);
    #2 reset = 1'b0;
  endtask

  task automatic test_bringup();
    habilita = 1'b1; load = 1'b1;
    valores = {3'd7, 3'd0, 3'd2, 3'd5};
    tick();
    load = 1'b0;
    for (int k = 1; k <= 26; k++) begin
      tick();
      n_vec++;
      if ({segmentos, anodos, ready} !== {m_seg, m_anod, m_ready}) begin
        n_err++;
        $display("FAIL bringup k=%0d: got seg=%b an=%b rdy=%b want seg=%b an=%b rdy=%b",
                 k, segmentos, anodos, ready, m_seg, m_anod, m_ready);
      end
      if (k == 1 || k == 25) begin
        n_vec++;
        if ({segmentos, anodos} !== {7'b0100100, 4'b1110}) begin
          n_err++;
          $display("FAIL bringup_digit0 k=%0d: got %b/%b want 0100100/1110", k, segmentos, anodos);
        end
      end
      if (k == 5) begin
        n_vec++;
        if (anodos !== 4'b1111) begin
          n_err++; $display("FAIL bringup_gap: got %b want 1111", anodos);
        end
      end
      if (k == 7) begin
        n_vec++;
        if ({segmentos, anodos} !== {7'b0010010, 4'b1101}) begin
          n_err++;
          $display("FAIL bringup_digit1: got %b/%b want 0010010/1101", segmentos, anodos);
        end
      end
      $display("bringup k=%0d seg=%b an=%b rdy=%b", k, segmentos, anodos, ready);
    end
  endtask

  task automatic test_midframe_load();
    int guard;
    guard = 0;
    // Wait until digit 1 is in its lit phase.
    while (!(m_on && (m_t % FRAME) >= DPER && (m_t % FRAME) < DPER + P) && guard < 3*FRAME) begin
      tick(); guard++;
    end
    n_vec++;
    if (guard >= 3*FRAME) begin
      n_err++; $display("FAIL midload_sync: got timeout want digit1 phase");
    end
    load = 1'b1; valores = {4{3'd1}};
    tick();
    valores = {4{3'd6}};
    n_vec++;
    if (ready !== 1'b0) begin
      n_err++; $display("FAIL midload_ready: got %b want 0", ready);
    end
    // Second load while ready is low must be ignored.
    tick();
    load = 1'b0;
    for (int k = 0; k < 2*FRAME; k++) begin
      tick();
      n_vec++;
      if ({segmentos, anodos, ready} !== {m_seg, m_anod, m_ready}) begin
        n_err++;
        $display("FAIL midload k=%0d: got seg=%b an=%b rdy=%b want seg=%b an=%b rdy=%b",
                 k, segmentos, anodos, ready, m_seg, m_anod, m_ready);
      end
      $display("midload k=%0d seg=%b an=%b rdy=%b", k, segmentos, anodos, ready);
    end
    n_vec++;
    if (ready !== 1'b1) begin
      n_err++; $display("FAIL midload_commit_ready: got %b want 1", ready);
    end
  endtask

  task automatic test_habilita_drop();
    int guard;
    guard = 0;
    while (!(m_on && (m_t % DPER) >= P) && guard < 2*FRAME) begin
      tick(); guard++;
    end
    n_vec++;
    if (guard >= 2*FRAME) begin
      n_err++; $display("FAIL drop_sync: got timeout want gap phase");
    end
    habilita = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_vec++;
      if ({segmentos, anodos, ready} !== {m_seg, m_anod, m_ready}) begin
        n_err++;
        $display("FAIL drop k=%0d: got seg=%b an=%b rdy=%b want seg=%b an=%b rdy=%b",
                 k, segmentos, anodos, ready, m_seg, m_anod, m_ready);
      end
    end
    n_vec++;
    if (anodos !== 4'b1111) begin
      n_err++; $display("FAIL drop_blank: got %b want 1111", anodos);
    end
    habilita = 1'b1;
    for (int k = 0; k < FRAME + 4; k++) begin
      tick();
      n_vec++;
      if ({segmentos, anodos, ready} !== {m_seg, m_anod, m_ready}) begin
        n_err++;
        $display("FAIL restart k=%0d: got seg=%b an=%b rdy=%b want seg=%b an=%b rdy=%b",
                 k, segmentos, anodos, ready, m_seg, m_anod, m_ready);
      end
      $display("restart k=%0d seg=%b an=%b rdy=%b", k, segmentos, anodos, ready);
    end
  endtask

  task automatic test_zero_digits();
    habilita = 1'b0;
    repeat (2) tick();
    habilita = 1'b1; load = 1'b1;
    valores = {3'd0, 3'd0, 3'd3, 3'd0};
    tick();
    load = 1'b0;
    for (int k = 0; k < FRAME + 2; k++) begin
      tick();
      n_vec++;
      if ({segmentos, anodos, ready} !== {m_seg, m_anod, m_ready}) begin
        n_err++;
        $display("FAIL zeros k=%0d: got seg=%b an=%b rdy=%b want seg=%b an=%b rdy=%b",
                 k, segmentos, anodos, ready, m_seg, m_anod, m_ready);
      end
      $display("zeros k=%0d seg=%b an=%b", k, segmentos, anodos);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 1200; k++) begin
      habilita = ($urandom_range(0, 99) < 96);
      load     = ($urandom_range(0, 7) == 0);
      valores  = 12'($urandom);
      tick();
      n_vec++;
      if ({segmentos, anodos, ready} !== {m_seg, m_anod, m_ready}) begin
        n_err++;
        $display("FAIL random k=%0d: got seg=%b an=%b rdy=%b want seg=%b an=%b rdy=%b",
                 k, segmentos, anodos, ready, m_seg, m_anod, m_ready);
      end
      $display("random k=%0d hab=%b ld=%b val=%h seg=%b an=%b rdy=%b",
               k, habilita, load, valores, segmentos, anodos, ready);
    end
    load = 1'b0;
  endtask

  task automatic test_async_reset();
    int guard;
    habilita = 1'b1;
    load = 1'b1; valores = {3'd4, 3'd4, 3'd4, 3'd4};
    guard = 0;
    // Arrange a pending set and a lit digit, then reset between edges.
    while (!(m_on && m_pv && (m_t % DPER) < P - 1) && guard < 3*FRAME) begin
      tick(); guard++;
    end
    load = 1'b0;
    tick();
    n_vec++;
    if (anodos === 4'b1111) begin
      n_err++; $display("FAIL areset_precond: got an=%b want a lit digit", anodos);
    end
    #2 reset = 1'b1;
    #1;
    model_reset();
    n_vec++;
    if ({segmentos, anodos, ready} !== {7'b1111111, 4'b1111, 1'b1}) begin
      n_err++;
      $display("FAIL areset_immediate: got seg=%b an=%b rdy=%b want 1111111 1111 1",
               segmentos, anodos, ready);
    end
    $display("areset seg=%b an=%b rdy=%b", segmentos, anodos, ready);
    @(posedge clk);
    #2 reset = 1'b0;
    // Pending data is lost: re-enable and scan shows zeros.
    for (int k = 0; k < FRAME; k++) begin
      tick();
      n_vec++;
      if ({segmentos, anodos, ready} !== {m_seg, m_anod, m_ready}) begin
        n_err++;
        $display("FAIL post_reset k=%0d: got seg=%b an=%b rdy=%b want seg=%b an=%b rdy=%b",
                 k, segmentos, anodos, ready, m_seg, m_anod, m_ready);
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_bringup();
    test_midframe_load();
    test_habilita_drop();
    test_zero_digits();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
